// File: rtl/periph_bus_dma_if.sv
// Peripheral bus between a bus initiator (master) and its responders (slave).
interface periph_bus_dma_if #(
  parameter int ADDR_W = 14
);
  logic              BusRequest;
  logic              BusGrant;
  logic [ADDR_W-1:0] AddressBus_P;
  logic [31:0]       DataWriteBus_P;
  logic              WriteAssert_P;
  logic [31:0]       DataReadBus_P;

  modport master (
    output BusRequest, AddressBus_P, DataWriteBus_P, WriteAssert_P,
    input  BusGrant, DataReadBus_P
  );

  modport slave (
    input  BusRequest, AddressBus_P, DataWriteBus_P, WriteAssert_P,
    output BusGrant, DataReadBus_P
  );
endinterface

// File: rtl/periph_bus_dma.sv
// Peripheral-bus block copier: one word at a time, read then write, only while granted.
// Define DMA_FILL_EN to add a fill mode that writes a latched pattern instead of copying.
//   state   | meaning
//   S_IDLE  | waiting for Start
//   S_REQ   | bus requested, waiting for grant
//   S_RADDR | source address on the bus
//   S_RWAIT | READ_LATENCY cycles until read data is valid
//   S_WRITE | one write strobe to the destination
//   S_DONE  | one-cycle completion pulse
module periph_bus_dma #(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 14
) (
  input  logic              CoreClock,
  input  logic              CoreReset_n,
  input  logic              Start,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W-1:0] WordCount,
`ifdef DMA_FILL_EN
  input  logic              FillMode,
  input  logic [31:0]       FillPattern,
`endif
  output logic              Busy,
  output logic              Done,
  periph_bus_dma_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RADDR, S_RWAIT, S_WRITE, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_cnt;
  logic [1:0]        r_lat;
  logic [31:0]       r_data;
  logic              w_latch;
  logic              w_capture;
  logic              w_advance;
  logic              w_lat_load;
  logic              w_lat_dec;
  logic              w_on_bus;
  logic              w_drive;
  logic              w_fill;
  logic [31:0]       w_wdata;

`ifdef DMA_FILL_EN
  logic              r_fill;
  logic [31:0]       r_pattern;

  always_ff @(posedge CoreClock or negedge CoreReset_n) begin
    if (!CoreReset_n) begin
      r_fill    <= 1'b0;
      r_pattern <= '0;
    end else if (w_latch) begin
      r_fill    <= FillMode;
      r_pattern <= FillPattern;
    end
  end

  assign w_fill  = r_fill;
  assign w_wdata = r_fill ? r_pattern : r_data;
`else
  assign w_fill  = 1'b0;
  assign w_wdata = r_data;
`endif

  always_ff @(posedge CoreClock or negedge CoreReset_n) begin
    if (!CoreReset_n) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    w_lat_load  = 1'b0;
    w_lat_dec   = 1'b0;
    w_on_bus    = (r_state == S_RADDR) || (r_state == S_RWAIT) || (r_state == S_WRITE);

    case (r_state)
      S_IDLE: begin
        if (Start && !Abort) begin
          w_latch     = 1'b1;
          w_state_nxt = (WordCount == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (bus.BusGrant) w_state_nxt = w_fill ? S_WRITE : S_RADDR;
      end
      S_RADDR: begin
        w_lat_load  = 1'b1;
        w_state_nxt = S_RWAIT;
      end
      S_RWAIT: begin
        if (r_lat == 2'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_WRITE;
        end else begin
          w_lat_dec   = 1'b1;
        end
      end
      S_WRITE: begin
        w_advance = 1'b1;
        if (r_cnt == ADDR_W'(1)) w_state_nxt = S_DONE;
        else                     w_state_nxt = w_fill ? S_WRITE : S_RADDR;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Losing the grant restarts the current word; nothing has been committed yet.
    if (w_on_bus && !bus.BusGrant) begin
      w_state_nxt = S_REQ;
      w_capture   = 1'b0;
      w_advance   = 1'b0;
      w_lat_load  = 1'b0;
      w_lat_dec   = 1'b0;
    end

    if ((r_state != S_IDLE) && Abort) begin
      w_state_nxt = S_IDLE;
      w_capture   = 1'b0;
      w_advance   = 1'b0;
      w_lat_load  = 1'b0;
      w_lat_dec   = 1'b0;
    end

    w_drive            = w_on_bus && bus.BusGrant && !Abort;
    Busy               = (r_state != S_IDLE);
    Done               = (r_state == S_DONE) && !Abort;
    bus.BusRequest     = (r_state == S_REQ) || w_on_bus;
    bus.AddressBus_P   = '0;
    bus.DataWriteBus_P = '0;
    bus.WriteAssert_P  = 1'b0;
    if (w_drive) begin
      if (r_state == S_WRITE) begin
        bus.AddressBus_P   = r_dst;
        bus.DataWriteBus_P = w_wdata;
        bus.WriteAssert_P  = 1'b1;
      end else begin
        bus.AddressBus_P   = r_src;
      end
    end
  end

  always_ff @(posedge CoreClock or negedge CoreReset_n) begin
    if (!CoreReset_n) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_cnt  <= '0;
      r_lat  <= '0;
      r_data <= '0;
    end else begin
      if (w_latch) begin
        r_src <= SrcAddr;
        r_dst <= DstAddr;
        r_cnt <= WordCount;
      end else if (w_advance) begin
        r_src <= r_src + ADDR_W'(1);
        r_dst <= r_dst + ADDR_W'(1);
        r_cnt <= r_cnt - ADDR_W'(1);
      end
      if (w_lat_load)     r_lat <= 2'(READ_LATENCY - 1);
      else if (w_lat_dec) r_lat <= r_lat - 2'd1;
      if (w_capture) r_data <= bus.DataReadBus_P;
    end
  end

endmodule

// File: tb/tb_periph_bus_dma.sv
// Bench for periph_bus_dma: memory responder, transaction-level write scoreboard and
// per-cycle Busy/BusRequest/Done/bus-quiet checks, plus literal expectations per scenario.
module tb_periph_bus_dma;
  localparam int AW = 14;

  logic          CoreClock = 1'b0;
  logic          CoreReset_n;
  logic          Start;
  logic          Abort;
  logic [AW-1:0] SrcAddr;
  logic [AW-1:0] DstAddr;
  logic [AW-1:0] WordCount;
  logic          Busy;
  logic          Done;
`ifdef DMA_FILL_EN
  logic          FillMode;
  logic [31:0]   FillPattern;
`endif

  periph_bus_dma_if #(.ADDR_W(AW)) bus ();

  periph_bus_dma #(.READ_LATENCY(1), .ADDR_W(AW)) dut (
    .CoreClock   (CoreClock),
    .CoreReset_n (CoreReset_n),
    .Start       (Start),
    .Abort       (Abort),
    .SrcAddr     (SrcAddr),
    .DstAddr     (DstAddr),
    .WordCount   (WordCount),
`ifdef DMA_FILL_EN
    .FillMode    (FillMode),
    .FillPattern (FillPattern),
`endif
    .Busy        (Busy),
    .Done        (Done),
    .bus         (bus)
  );

  always #5 CoreClock = ~CoreClock;

  int cyc = 0;
  always @(posedge CoreClock) cyc <= cyc + 1;

  // Responder: one-cycle read latency, writes land in memory.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge CoreClock) begin
    bus.DataReadBus_P <= mem[bus.AddressBus_P];
    if (bus.WriteAssert_P) mem[bus.AddressBus_P] <= bus.DataWriteBus_P;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } wr_t;

  wr_t           exp_q [$];
  int            wr_cyc [$];
  logic [AW-1:0] wr_addr [$];
  logic [31:0]   wr_data [$];
  bit            mon_en   = 1'b0;
  int            t0       = 0;
  int            exp_done = -1;
  int            exp_n    = 0;
  int            done_cyc = -1;
  bit            fill     = 1'b0;
  logic [31:0]   pattern  = '0;
  int            mon_rel;
  wr_t           mon_e;

  // Expected writes in order; earlier writes are visible to later reads (ascending overlap).
  task automatic plan(logic [AW-1:0] s, logic [AW-1:0] d, int n);
    logic [31:0] shadow [int];
    int          sa;
    int          da;
    logic [31:0] v;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      sa = (int'(s) + i) % (1 << AW);
      da = (int'(d) + i) % (1 << AW);
      if (fill)                   v = pattern;
      else if (shadow.exists(sa)) v = shadow[sa];
      else                        v = mem[sa];
      shadow[da] = v;
      exp_q.push_back('{a: AW'(da), d: v});
    end
  endtask

  always @(negedge CoreClock) begin
    if (mon_en && CoreReset_n) begin
      mon_rel = cyc - t0;
      if (bus.WriteAssert_P) begin
        wr_cyc.push_back(mon_rel);
        wr_addr.push_back(bus.AddressBus_P);
        wr_data.push_back(bus.DataWriteBus_P);
        if (exp_q.size() == 0) begin
          chk("write_count", wr_cyc.size(), exp_n);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", bus.AddressBus_P, mon_e.a);
          chk("wr_data", bus.DataWriteBus_P, mon_e.d);
        end
      end
      if (!bus.BusGrant || !Busy)
        chk("bus_quiet", {bus.AddressBus_P, bus.DataWriteBus_P, bus.WriteAssert_P}, '0);
      if (exp_done >= 0) begin
        chk("busy", Busy, (mon_rel > 0) && (mon_rel <= exp_done));
        chk("busreq", bus.BusRequest, (exp_n > 0) && (mon_rel > 0) && (mon_rel < exp_done));
        chk("done", Done, mon_rel == exp_done);
      end
      if (Done) done_cyc = mon_rel;
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge CoreClock);
      #1;
    end
  endtask

  // Leaves the caller one cycle after the Start cycle (t0+1).
  task automatic start_xfer(logic [AW-1:0] s, logic [AW-1:0] d, logic [AW-1:0] n, int expd);
    plan(s, d, int'(n));
    tick(1);
    SrcAddr   = s;
    DstAddr   = d;
    WordCount = n;
    Start     = 1'b1;
    t0        = cyc;
    exp_done  = expd;
    exp_n     = int'(n);
    done_cyc  = -1;
    wr_cyc.delete();
    wr_addr.delete();
    wr_data.delete();
    mon_en    = 1'b1;
    tick(1);
    Start     = 1'b0;
  endtask

  task automatic finish_test(string name, int maxc, int exp_d);
    for (int k = 0; k < maxc && done_cyc < 0; k++) @(negedge CoreClock);
    tick(2);
    chk({name, "_done_cycle"}, done_cyc, exp_d);
    chk({name, "_pending"}, exp_q.size(), 0);
    mon_en   = 1'b0;
    exp_done = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] wrap_a [3];
    wrap_a = '{14'h3FFF, 14'h0000, 14'h0001};

    CoreReset_n   = 1'b0;
    Start         = 1'b0;
    Abort         = 1'b0;
    SrcAddr       = '0;
    DstAddr       = '0;
    WordCount     = '0;
    bus.BusGrant  = 1'b1;
`ifdef DMA_FILL_EN
    FillMode      = 1'b0;
    FillPattern   = '0;
`endif
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h5A00_0000 | i;
    for (int i = 0; i < 4; i++) mem[14'h0010 + i] = 32'hA0 + i;
    mem[14'h0020] = 32'hB0;
    mem[14'h0021] = 32'hB1;
    mem[14'h3FFE] = 32'h11;
    mem[14'h3FFF] = 32'h22;
    mem[14'h0000] = 32'h33;

    tick(3);
    @(negedge CoreClock);
    chk("reset_outputs", {Busy, Done, bus.BusRequest, bus.AddressBus_P, bus.DataWriteBus_P,
                          bus.WriteAssert_P}, '0);
    CoreReset_n = 1'b1;
    tick(2);

    // Copy 4 words; a second Start mid-transfer must be ignored.
    start_xfer(14'h0010, 14'h0100, 14'd4, 14);
    tick(4);
    SrcAddr = 14'h3000; DstAddr = 14'h0000; WordCount = 14'd7; Start = 1'b1;
    tick(1);
    Start = 1'b0;
    finish_test("copy", 40, 14);
    for (int i = 0; i < 4; i++) begin
      chk("copy_wr_cycle", (i < wr_cyc.size()) ? wr_cyc[i] : -1, 4 + 3 * i);
      chk("copy_wr_addr", (i < wr_addr.size()) ? wr_addr[i] : 14'h0, 14'h0100 + i);
      chk("copy_wr_data", (i < wr_data.size()) ? wr_data[i] : 32'h0, 32'hA0 + i);
    end
    chk("copy_wr_total", wr_cyc.size(), 4);

    // Zero count: Done one cycle after Start, no bus activity.
    start_xfer(14'h0010, 14'h0100, 14'd0, 1);
    finish_test("zero", 10, 1);
    chk("zero_wr_total", wr_cyc.size(), 0);

    // Grant dropped for cycles 3..5 (first word in RWAIT); regrant seen at end of cycle 6.
    start_xfer(14'h0020, 14'h0120, 14'd2, 13);
    tick(2);
    bus.BusGrant = 1'b0;
    @(negedge CoreClock);
    chk("grantloss_req_held", bus.BusRequest, 1'b1);
    tick(3);
    bus.BusGrant = 1'b1;
    finish_test("grantloss", 40, 13);
    chk("grantloss_wr_total", wr_cyc.size(), 2);
    chk("grantloss_data0", (wr_data.size() > 0) ? wr_data[0] : 32'h0, 32'hB0);
    chk("grantloss_data1", (wr_data.size() > 1) ? wr_data[1] : 32'h0, 32'hB1);

    // Wrap with overlap: each write feeds the next read, so all three words carry 0x11.
    start_xfer(14'h3FFE, 14'h3FFF, 14'd3, 11);
    finish_test("wrap", 40, 11);
    for (int i = 0; i < 3; i++) begin
      chk("wrap_wr_addr", (i < wr_addr.size()) ? wr_addr[i] : 14'h1234, wrap_a[i]);
      chk("wrap_wr_data", (i < wr_data.size()) ? wr_data[i] : 32'h0, 32'h11);
    end

    // Abort during the second WRITE (cycle 7) of a 4-word copy.
    start_xfer(14'h0010, 14'h0300, 14'd4, -1);
    tick(6);
    Abort = 1'b1;
    @(negedge CoreClock);
    chk("abort_no_strobe", bus.WriteAssert_P, 1'b0);
    tick(1);
    Abort = 1'b0;
    @(negedge CoreClock);
    chk("abort_busy_next", Busy, 1'b0);
    tick(10);
    chk("abort_no_done", done_cyc, -1);
    chk("abort_wr_total", wr_cyc.size(), 1);
    chk("abort_wr_cycle", (wr_cyc.size() > 0) ? wr_cyc[0] : -1, 4);
    mon_en = 1'b0;

    // Abort together with Start in IDLE: nothing starts.
    tick(1);
    WordCount = 14'd2; Start = 1'b1; Abort = 1'b1;
    tick(1);
    Start = 1'b0; Abort = 1'b0;
    @(negedge CoreClock);
    chk("abort_over_start", {Busy, bus.BusRequest}, 2'b00);

    // Reset in the middle of RWAIT clears every output at once.
    start_xfer(14'h0010, 14'h0400, 14'd4, -1);
    tick(2);
    @(negedge CoreClock);
    chk("rst_pre_busreq", bus.BusRequest, 1'b1);
    mon_en = 1'b0;
    #2;
    CoreReset_n = 1'b0;
    #1;
    chk("rst_async_outputs", {Busy, Done, bus.BusRequest, bus.AddressBus_P, bus.DataWriteBus_P,
                              bus.WriteAssert_P}, '0);
    tick(2);
    CoreReset_n = 1'b1;
    tick(2);
    @(negedge CoreClock);
    chk("rst_stays_idle", {Busy, bus.WriteAssert_P}, 2'b00);

`ifdef DMA_FILL_EN
    fill = 1'b1;
    pattern = 32'hDEADBEEF;
    FillMode = 1'b1;
    FillPattern = 32'hDEADBEEF;
    start_xfer(14'h0010, 14'h0200, 14'd3, 5);
    finish_test("fill", 20, 5);
    for (int i = 0; i < 3; i++) begin
      chk("fill_wr_cycle", (i < wr_cyc.size()) ? wr_cyc[i] : -1, 2 + i);
      chk("fill_wr_data", (i < wr_data.size()) ? wr_data[i] : 32'h0, 32'hDEADBEEF);
    end
    FillMode = 1'b0;
    fill = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
